// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing constants and helpers.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_POL    = 0;
  localparam int DEF_V_POL    = 0;

  function automatic int seg_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// pix_tick_div: system-clock to pixel-rate divider.
// tick is high in the enabled cycle where the count wraps.
module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  // Count enabled cycles, wrap on the last one of each pixel
  always_comb begin
    tick      = enable && (div_cnt_q == LAST);
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
  end

  // Divider state; holds while paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Single clock; pixel advance qualified by an internal tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_POL    = DEF_H_POL,
  parameter int V_POL    = DEF_V_POL,
  parameter int COORD_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               h_sync,
  output logic               v_sync,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic               active_area,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOT = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if ((2 ** COORD_W) < MAX_TOT) begin : g_width_err
    $error("vga_timing_gen: COORD_W too small for raster totals");
  end

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SB   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SE   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SB   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SE   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  logic               tick;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic               active_q, active_d;
  logic               pix_tick_q, pix_tick_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  pix_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // Raster counters advance one pixel per tick
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Decode from next counter values so outputs align with coords
  always_comb begin
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    active_d      = active_q;
    pix_tick_d    = tick;
    line_start_d  = tick && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
    if (tick) begin
      h_sync_d = ((h_cnt_d >= H_SB) && (h_cnt_d <= H_SE)) ? H_ON : ~H_ON;
      v_sync_d = ((v_cnt_d >= V_SB) && (v_cnt_d <= V_SE)) ? V_ON : ~V_ON;
      active_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    end
  end

  // Output and counter registers; reset parks on the last blank pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      h_sync_q      <= ~H_ON;
      v_sync_q      <= ~V_ON;
      active_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign coord_x     = h_cnt_q;
  assign coord_y     = v_cnt_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign active_area = active_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
